// File: rtl/pipe_return_buffer.sv
// pipe_return_buffer: admits items into an external fixed-latency delay line,
// tracks live stages and captures tail data into a credit-guarded FIFO.
//
// Ports:
//   i_clk, i_reset_n     clock (rising edge), async active-low reset
//   i_in_valid           upstream item present
//   o_in_ready           a credit is free (registered state only)
//   o_pipe_launch        head-valid of the delay line (admit pulse)
//   i_pipe_data          tail data of the delay line
//   o_out_data           FIFO head
//   o_out_valid          FIFO non-empty
//   i_out_ready          downstream accepts the head
//   o_used               credits in use: in flight plus buffered

module pipe_return_buffer #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  output logic                     o_pipe_launch,
  input  logic [WIDTH-1:0]         i_pipe_data,
  output logic [WIDTH-1:0]         o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [$clog2(DEPTH):0]   o_used
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [LATENCY-1:0] vsr_q;
  logic [LATENCY-1:0] vsr_d;
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q;
  logic [PW-1:0]      rd_ptr_d;
  logic [PW-1:0]      used_q;
  logic [PW-1:0]      used_d;

  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic in_ready;
  logic launch;
  logic pop;
  logic capture;
  logic out_valid;

  // Admission looks only at the registered credit count, so a pop
  // returns its credit one cycle later and no path from i_out_ready
  // or i_in_valid reaches o_in_ready.
  assign in_ready  = (used_q < PW'(DEPTH)) & i_reset_n;
  assign launch    = i_in_valid & in_ready;
  assign out_valid = (wr_ptr_q != rd_ptr_q);
  assign pop       = out_valid & i_out_ready;
  assign capture   = vsr_q[LATENCY-1];

  always_comb begin
    vsr_d    = '0;
    vsr_d[0] = launch;
    for (int i = 1; i < LATENCY; i++) begin
      vsr_d[i] = vsr_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (capture) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_comb begin
    used_d = used_q;
    unique case (1'b1)
      launch & ~pop: used_d = used_q + PW'(1);
      pop & ~launch: used_d = used_q - PW'(1);
      default:       used_d = used_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vsr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      vsr_q    <= vsr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  // Storage holds no reset; the pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_pipe_data;
    end
  end

  assign o_in_ready    = in_ready;
  assign o_pipe_launch = launch;
  assign o_out_valid   = out_valid;
  assign o_out_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign o_used        = used_q;

endmodule
